// File: rtl/count_monitor.sv
// Passive observer of a 4-bit load/count counter: classifies each step, counts wraps,
// and runs an armable compare sequence. Optional build macro: CNT_MON_STICKY_ERR_EN.
module count_monitor #(
    parameter int WIDTH  = 4,
    parameter int WRAP_W = 8,
    parameter int HITS   = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [WIDTH-1:0]  count_in,
    input  logic [WIDTH-1:0]  cmp_val,
    input  logic              arm,
    input  logic              disarm,
    input  logic              err_clr,
    output logic [WRAP_W-1:0] wrap_cnt,
    output logic              jump_err,
    output logic              irq,
    output logic              done,
    output logic              busy
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ARMED = 2'd1,
        S_DONE  = 2'd2
    } state_t;

    localparam logic [3:0]        HITS_L   = 4'(HITS);
    localparam logic [WIDTH-1:0]  ONE_W    = {{(WIDTH-1){1'b0}}, 1'b1};
    localparam logic [WRAP_W-1:0] ONE_WRAP = {{(WRAP_W-1){1'b0}}, 1'b1};

    state_t            r_state;
    state_t            w_state_next;
    logic [3:0]        r_hit_cnt;
    logic [3:0]        w_hit_next;
    logic              w_irq_next;
    logic [WIDTH-1:0]  r_prev;
    logic              r_prev_vld;
    logic [WRAP_W-1:0] r_wrap_cnt;
    logic              r_jump_err;
    logic              r_irq;

    logic [WIDTH-1:0]  w_prev_inc;
    logic              w_hold;
    logic              w_inc;
    logic              w_jump;
    logic              w_wrap;
    logic              w_entry;

    // Nothing is classified until a previous sample exists.
    assign w_prev_inc = r_prev + ONE_W;
    assign w_hold     = (count_in == r_prev);
    assign w_inc      = (count_in == w_prev_inc);
    assign w_jump     = r_prev_vld && !w_hold && !w_inc;
    assign w_wrap     = r_prev_vld && w_inc && (r_prev == {WIDTH{1'b1}});
    assign w_entry    = r_prev_vld && (count_in == cmp_val) && !w_hold;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_prev     <= '0;
            r_prev_vld <= 1'b0;
            r_wrap_cnt <= '0;
        end else begin
            r_prev     <= count_in;
            r_prev_vld <= 1'b1;
            if (w_wrap && (r_wrap_cnt != {WRAP_W{1'b1}})) begin
                r_wrap_cnt <= r_wrap_cnt + ONE_WRAP;
            end
        end
    end

`ifdef CNT_MON_STICKY_ERR_EN
    // A new jump takes priority over a clear in the same cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_jump_err <= 1'b0;
        end else if (w_jump) begin
            r_jump_err <= 1'b1;
        end else if (err_clr) begin
            r_jump_err <= 1'b0;
        end
    end
`else
    logic w_unused_err_clr;
    assign w_unused_err_clr = err_clr;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_jump_err <= 1'b0;
        end else begin
            r_jump_err <= w_jump;
        end
    end
`endif

    always_comb begin
        w_state_next = r_state;
        w_hit_next   = r_hit_cnt;
        w_irq_next   = 1'b0;
        if (disarm) begin
            w_state_next = S_IDLE;
            w_hit_next   = 4'd0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (arm) begin
                        w_state_next = S_ARMED;
                        w_hit_next   = 4'd0;
                    end
                end
                S_ARMED: begin
                    // A restart swallows any entry seen in the same cycle.
                    if (arm) begin
                        w_hit_next = 4'd0;
                    end else if (w_entry) begin
                        if ((r_hit_cnt + 4'd1) == HITS_L) begin
                            w_state_next = S_DONE;
                            w_irq_next   = 1'b1;
                        end
                        w_hit_next = r_hit_cnt + 4'd1;
                    end
                end
                S_DONE: begin
                    if (arm) begin
                        w_state_next = S_ARMED;
                        w_hit_next   = 4'd0;
                    end
                end
                default: begin
                    w_state_next = S_IDLE;
                    w_hit_next   = 4'd0;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= S_IDLE;
            r_hit_cnt <= 4'd0;
            r_irq     <= 1'b0;
        end else begin
            r_state   <= w_state_next;
            r_hit_cnt <= w_hit_next;
            r_irq     <= w_irq_next;
        end
    end

    assign wrap_cnt = r_wrap_cnt;
    assign jump_err = r_jump_err;
    assign irq      = r_irq;
    assign done     = (r_state == S_DONE);
    assign busy     = (r_state == S_ARMED);

endmodule

// File: tb/tb_count_monitor.sv
// Directed and random stimulus for count_monitor, checked against an integer-level model
// of the classification, wrap and compare rules.
module tb_count_monitor;

    localparam int HITS = 2;

    logic       clk = 1'b0;
    logic       rst;
    logic [3:0] count_in;
    logic [3:0] cmp_val;
    logic       arm;
    logic       disarm;
    logic       err_clr;
    logic [7:0] wrap_cnt;
    logic       jump_err;
    logic       irq;
    logic       done;
    logic       busy;

    count_monitor #(.WIDTH(4), .WRAP_W(8), .HITS(HITS)) dut (
        .clk      (clk),
        .rst      (rst),
        .count_in (count_in),
        .cmp_val  (cmp_val),
        .arm      (arm),
        .disarm   (disarm),
        .err_clr  (err_clr),
        .wrap_cnt (wrap_cnt),
        .jump_err (jump_err),
        .irq      (irq),
        .done     (done),
        .busy     (busy)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int irq_seen = 0;
    int cur = 0;
    int step_no = 0;

    // Model state: m_prev < 0 means no previous sample since reset.
    int m_prev = -1;
    int m_wrap = 0;
    int m_jerr = 0;
    int m_irq = 0;
    int m_armed = 0;
    int m_done = 0;
    int m_hits = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input int exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s step=%0d observed=%0h expected=%0h", tag, step_no, obs, exp);
        end
    endtask

    task automatic model(input int cnt, input int cmp, input bit a, input bit d, input bit c, input bit r);
        bit valid, hold, inc, jump, entry;
        if (r) begin
            m_prev = -1; m_wrap = 0; m_jerr = 0; m_irq = 0;
            m_armed = 0; m_done = 0; m_hits = 0;
            return;
        end
        valid = (m_prev >= 0);
        hold  = valid && (cnt == m_prev);
        inc   = valid && (cnt == (m_prev + 1) % 16);
        jump  = valid && !hold && !inc;
        if (inc && m_prev == 15 && m_wrap < 255) m_wrap++;
`ifdef CNT_MON_STICKY_ERR_EN
        if (jump) m_jerr = 1;
        else if (c) m_jerr = 0;
`else
        m_jerr = jump ? 1 : 0;
`endif
        entry = valid && (cnt == cmp) && !hold;
        m_irq = 0;
        if (d) begin
            m_armed = 0; m_done = 0; m_hits = 0;
        end else if (a) begin
            m_armed = 1; m_done = 0; m_hits = 0;
        end else if (m_armed && entry) begin
            m_hits++;
            if (m_hits == HITS) begin
                m_irq = 1; m_armed = 0; m_done = 1;
            end
        end
        m_prev = cnt;
    endtask

    task automatic step(input int cnt, input int cmp, input bit a, input bit d, input bit c, input bit r);
        count_in = cnt[3:0];
        cmp_val  = cmp[3:0];
        arm      = a;
        disarm   = d;
        err_clr  = c;
        rst      = r;
        @(posedge clk);
        model(cnt, cmp, a, d, c, r);
        #1;
        step_no++;
        cur = cnt;
        if (irq === 1'b1) irq_seen++;
        $display("step %0d rst=%0d cnt=%0h cmp=%0h arm=%0d dis=%0d clr=%0d -> wrap=%0h jerr=%0d irq=%0d done=%0d busy=%0d",
                 step_no, r, cnt, cmp, a, d, c, wrap_cnt, jump_err, irq, done, busy);
        chk("wrap_cnt", {24'd0, wrap_cnt}, m_wrap);
        chk("jump_err", {31'd0, jump_err}, m_jerr);
        chk("irq",      {31'd0, irq},      m_irq);
        chk("done",     {31'd0, done},     m_done);
        chk("busy",     {31'd0, busy},     m_armed);
    endtask

    initial begin
        rst = 1'b1; count_in = '0; cmp_val = '0;
        arm = 1'b0; disarm = 1'b0; err_clr = 1'b0;

        // Reset, then one full count with wrap; first sample unclassified.
        step(7, 0, 0, 0, 0, 1);
        step(7, 0, 0, 0, 0, 1);
        for (int i = 0; i < 16; i++) step(i, 0, 0, 0, 0, 0);
        step(0, 0, 0, 0, 0, 0);
        chk("wrap_after_one", {24'd0, wrap_cnt}, 1);

        // Saturation of the wrap counter.
        for (int w = 0; w < 260; w++)
            for (int i = 1; i <= 16; i++) step(i % 16, 0, 0, 0, 0, 0);
        chk("wrap_saturated", {24'd0, wrap_cnt}, 255);
        step(0, 0, 0, 0, 0, 1);

        // Compare sequence at A, with a 3-cycle hold on A counting once.
        irq_seen = 0;
        step(0, 10, 1, 0, 0, 0);
        for (int i = 1; i <= 10; i++) step(i, 10, 0, 0, 0, 0);
        step(10, 10, 0, 0, 0, 0);
        step(10, 10, 0, 0, 0, 0);
        for (int i = 11; i < 16; i++) step(i, 10, 0, 0, 0, 0);
        for (int i = 0; i <= 11; i++) step(i, 10, 0, 0, 0, 0);
        chk("irq_count", irq_seen, 1);
        chk("done_after", {31'd0, done}, 1);

        // Load jump, clear, jump to 0, jump coincident with clear.
        step(3, 15, 0, 0, 0, 0);
        step(4, 15, 0, 0, 0, 0);
        step(5, 15, 0, 0, 0, 0);
        step(10, 15, 0, 0, 0, 0);
        step(10, 15, 0, 0, 0, 0);
        step(11, 15, 0, 0, 1, 0);
        step(12, 15, 0, 0, 0, 0);
        step(5, 15, 0, 0, 0, 0);
        step(0, 15, 0, 0, 0, 0);
        step(7, 15, 0, 0, 1, 0);
        step(8, 15, 0, 0, 1, 0);

        // arm+disarm together, restart after one hit, jump entry, arm on entry cycle.
        irq_seen = 0;
        step(1, 3, 1, 1, 0, 0);
        step(2, 3, 1, 0, 0, 0);
        step(3, 3, 0, 0, 0, 0);
        step(4, 3, 1, 0, 0, 0);
        step(3, 3, 0, 0, 0, 0);
        step(4, 3, 0, 0, 0, 0);
        step(3, 3, 0, 0, 0, 0);
        step(4, 3, 0, 0, 0, 0);
        step(3, 3, 1, 0, 0, 0);
        step(4, 3, 0, 0, 0, 0);
        step(3, 3, 0, 0, 0, 0);
        step(4, 3, 0, 0, 0, 0);
        step(3, 3, 0, 0, 0, 0);
        chk("irq_count_restart", irq_seen, 2);

        // Reset while armed with one hit, then an unclassified jump-like sample.
        step(5, 6, 1, 0, 0, 0);
        step(6, 6, 0, 0, 0, 0);
        step(7, 6, 0, 0, 0, 1);
        step(9, 6, 0, 0, 0, 0);
        step(6, 6, 0, 0, 0, 0);

        // Random traffic.
        begin
            int cmp = 0;
            for (int n = 0; n < 2000; n++) begin
                int sel, nxt;
                bit a, d, c, r;
                sel = $urandom_range(0, 9);
                if (sel < 5)      nxt = (cur + 1) % 16;
                else if (sel < 8) nxt = cur;
                else              nxt = $urandom_range(0, 15);
                if ($urandom_range(0, 49) == 0) cmp = $urandom_range(0, 15);
                a = ($urandom_range(0, 19) == 0);
                d = ($urandom_range(0, 59) == 0);
                c = ($urandom_range(0, 7) == 0);
                r = ($urandom_range(0, 299) == 0);
                step(nxt, cmp, a, d, c, r);
            end
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
